// File: rtl/xor_accum_pipe.sv
// xor_accum_pipe: handshaked bitwise-XOR datapath with multi-beat accumulation.
// Each accepted beat extends A and B to EW = max(AW,BW,OW) bits, XORs them,
// keeps the low OW bits and folds the result into a per-packet accumulator.
// The beat carrying in_last produces one registered result per packet.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       input beat handshake
//   in_a, in_b              operands
//   in_a_signed/in_b_signed operand signedness (signed only if both are set)
//   in_last                 final beat of packet
//   clr                     synchronous discard of the partial packet
//   out_valid/out_ready     result handshake
//   out_data                packet XOR result
//   out_beats               beats in packet, saturating at 2^CW-1
module xor_accum_pipe #(
  parameter int AW = 9,
  parameter int BW = 6,
  parameter int OW = 16,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_a,
  input  logic [BW-1:0] in_b,
  input  logic          in_a_signed,
  input  logic          in_b_signed,
  input  logic          in_last,
  input  logic          clr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic [CW-1:0] out_beats
);

  localparam int ABW = (AW > BW) ? AW : BW;
  localparam int EW  = (ABW > OW) ? ABW : OW;

  typedef enum logic {IDLE, ACCUM} state_t;

  // registered result bundle
  typedef struct packed {
    logic          vld;
    logic [OW-1:0] data;
    logic [CW-1:0] beats;
  } rsp_t;

  state_t        state, state_nxt;
  logic [OW-1:0] acc, acc_nxt, acc_base, acc_fold, beat_val;
  logic [CW-1:0] cnt, cnt_nxt, cnt_base, cnt_inc;
  logic [EW-1:0] ext_a, ext_b;
  logic          both_signed, accept;
  rsp_t          rsp, rsp_nxt;

  assign in_ready = !rsp.vld || out_ready;
  assign accept   = in_valid && in_ready;

  // Mixed signedness makes the whole expression unsigned, so both operands
  // zero-extend; a width cast of a $signed value sign-extends.
  assign both_signed = in_a_signed && in_b_signed;
  assign ext_a = both_signed ? EW'($signed(in_a)) : EW'(in_a);
  assign ext_b = both_signed ? EW'($signed(in_b)) : EW'(in_b);
  assign beat_val = OW'(ext_a ^ ext_b);

  // clr takes effect before any beat accepted in the same cycle
  assign acc_base = clr ? '0 : acc;
  assign cnt_base = clr ? '0 : cnt;
  assign acc_fold = acc_base ^ beat_val;
  assign cnt_inc  = (cnt_base == {CW{1'b1}}) ? cnt_base : cnt_base + 1'b1;

  always_comb begin
    state_nxt   = clr ? IDLE : state;
    acc_nxt     = acc_base;
    cnt_nxt     = cnt_base;
    rsp_nxt     = rsp;
    rsp_nxt.vld = rsp.vld && !out_ready;
    if (accept) begin
      if (in_last) begin
        rsp_nxt.vld   = 1'b1;
        rsp_nxt.data  = acc_fold;
        rsp_nxt.beats = cnt_inc;
        acc_nxt       = '0;
        cnt_nxt       = '0;
        state_nxt     = IDLE;
      end else begin
        acc_nxt   = acc_fold;
        cnt_nxt   = cnt_inc;
        state_nxt = ACCUM;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      rsp   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      rsp   <= rsp_nxt;
    end
  end

  assign out_valid = rsp.vld;
  assign out_data  = rsp.data;
  assign out_beats = rsp.beats;

endmodule

// File: tb/tb_xor_accum_pipe.sv
// Directed bench for xor_accum_pipe with default parameters (9/6/16/4).
module tb_xor_accum_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [8:0]  in_a = '0;
  logic [5:0]  in_b = '0;
  logic        in_a_signed = 1'b0;
  logic        in_b_signed = 1'b0;
  logic        in_last = 1'b0;
  logic        clr = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [3:0]  out_beats;

  int n_chk = 0;
  int n_err = 0;

  xor_accum_pipe #(.AW(9), .BW(6), .OW(16), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .in_a_signed(in_a_signed), .in_b_signed(in_b_signed),
    .in_last(in_last), .clr(clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_beats(out_beats)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // offer one beat from the falling edge, hold it across one rising edge
  task automatic send(input logic [8:0] a, input logic [5:0] b, input logic as,
                      input logic bs, input logic last, input logic c);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b;
    in_a_signed = as; in_b_signed = bs; in_last = last; clr = c;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; clr = 1'b0;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_beats", 32'(out_beats), 32'd0);
    chk("rst_ready", 32'(in_ready),  32'd1);
    @(negedge clk); rst_n = 1'b1;

    // unsigned single beat
    send(9'h1FF, 6'h3F, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("uns_valid", 32'(out_valid), 32'd1);
    chk("uns_data",  32'(out_data),  32'h01C0);
    chk("uns_beats", 32'(out_beats), 32'd1);

    // both signed, then mixed signedness (back to back)
    send(9'h1FF, 6'h20, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("sgn_data",  32'(out_data),  32'h001F);
    chk("sgn_valid", 32'(out_valid), 32'd1);
    send(9'h1FF, 6'h20, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("mix_data",  32'(out_data),  32'h01DF);

    // three-beat accumulation
    send(9'd1, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("acc1_valid", 32'(out_valid), 32'd0);
    send(9'd2, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("acc2_valid", 32'(out_valid), 32'd0);
    send(9'd4, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("acc3_valid", 32'(out_valid), 32'd1);
    chk("acc3_data",  32'(out_data),  32'h0007);
    chk("acc3_beats", 32'(out_beats), 32'd3);

    // backpressure: beat offered but must not be taken for 5 cycles
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 9'd5; in_b = 6'd0;
    in_a_signed = 1'b0; in_b_signed = 1'b0; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_ready", 32'(in_ready),  32'd0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data",  32'(out_data),  32'h0007);
      chk("bp_beats", 32'(out_beats), 32'd3);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    chk("drain_valid", 32'(out_valid), 32'd1);
    chk("drain_data",  32'(out_data),  32'h0005);
    chk("drain_beats", 32'(out_beats), 32'd1);

    // clr together with a last beat restarts the packet
    send(9'd1, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(9'd2, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(9'd8, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("clr_data",  32'(out_data),  32'h0008);
    chk("clr_beats", 32'(out_beats), 32'd1);

    // clr alone drops the partial packet and leaves output untouched
    send(9'd1, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
    send(9'd4, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr2_data",  32'(out_data),  32'h0004);
    chk("clr2_beats", 32'(out_beats), 32'd1);

    // asynchronous reset while a result is pending
    @(negedge clk); out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data",  32'(out_data),  32'd0);
    chk("arst_beats", 32'(out_beats), 32'd0);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;

    // reset mid-packet discards the accumulator
    send(9'd1, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(9'd2, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("mrst_valid", 32'(out_valid), 32'd0);
    #1 rst_n = 1'b1;
    send(9'd3, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("mrst_data",  32'(out_data),  32'h0003);
    chk("mrst_beats", 32'(out_beats), 32'd1);

    // 20 beats a=1..20: counter saturates at 15, XOR of 1..20 is 20
    for (int i = 1; i <= 20; i++) begin
      send(9'(i), 6'd0, 1'b0, 1'b0, (i == 20), 1'b0);
      if (i == 17) chk("sat_mid_valid", 32'(out_valid), 32'd0);
    end
    chk("sat_valid", 32'(out_valid), 32'd1);
    chk("sat_data",  32'(out_data),  32'h0014);
    chk("sat_beats", 32'(out_beats), 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
